// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_sub_bit_cell.sv
// One-bit subtract cell: full adder fed with the inverted subtrahend bit.
module sub_bit_cell (
  input  logic a,
  input  logic b_n,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g;
  logic pc;

  assign p    = a ^ b_n;
  assign s    = p ^ cin;
  assign g    = a & b_n;
  assign pc   = p & cin;
  assign cout = g | pc;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit two's-complement subtractor (diff = a - b), LSB first,
// one bit per clock through a single sub_bit_cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         overflow
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // valid and data are held by the sender until that edge; in_ready and
  // out_valid are registered and never both high in the same cycle.

  state_e        state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [N-1:0]  diff_sh_q, diff_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          borrow_q, borrow_d;
  logic          overflow_q, overflow_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          cell_s;
  logic          cell_cout;
  logic [N-1:0]  s_msb;

  (* keep_hierarchy = "yes" *)
  sub_bit_cell u_cell (
    .a    (a_sh_q[0]),
    .b_n  (~b_sh_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    diff_sh_d   = diff_sh_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    s_msb       = '0;
    s_msb[N-1]  = cell_s;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d     = a;
          b_sh_d     = b;
          diff_sh_d  = '0;
          carry_d    = 1'b1;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        diff_sh_d = (diff_sh_q >> 1) | s_msb;
        carry_d   = cell_cout;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB on this edge.
          diff_d      = diff_sh_d;
          borrow_d    = ~cell_cout;
          overflow_d  = carry_q ^ cell_cout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      diff_sh_q   <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      diff_sh_q   <= diff_sh_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three builds (N=4, N=1, N=8) driven by a
// vector table, hand-written corner sequences and random operands.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       iv  [3];
  logic       orv [3];
  logic [7:0] av  [3];
  logic [7:0] bv  [3];
  logic       irv [3];
  logic       ovv [3];
  logic       bov [3];
  logic       ofv [3];
  logic [7:0] dv  [3];
  logic [3:0] d4;
  logic [0:0] d1;
  logic [7:0] d8;

  int n_checks;
  int n_err;
  logic [9:0] exp_q[$];

  typedef struct {
    int         w;
    logic [7:0] a;
    logic [7:0] b;
    int         hold;
    bit         poke;
    logic [7:0] d;
    logic       bo;
    logic       of;
  } vec_t;

  vec_t vecs[12];

  assign dv[0] = {4'b0, d4};
  assign dv[1] = {7'b0, d1};
  assign dv[2] = d8;

  serial_subtractor #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irv[0]),
    .a(av[0][3:0]), .b(bv[0][3:0]), .out_valid(ovv[0]), .out_ready(orv[0]),
    .diff(d4), .borrow(bov[0]), .overflow(ofv[0])
  );

  serial_subtractor #(.N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irv[1]),
    .a(av[1][0:0]), .b(bv[1][0:0]), .out_valid(ovv[1]), .out_ready(orv[1]),
    .diff(d1), .borrow(bov[1]), .overflow(ofv[1])
  );

  serial_subtractor #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irv[2]),
    .a(av[2]), .b(bv[2]), .out_valid(ovv[2]), .out_ready(orv[2]),
    .diff(d8), .borrow(bov[2]), .overflow(ofv[2])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nw(input int w);
    case (w)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [9:0] model(input int n, input logic [7:0] a, input logic [7:0] b);
    int mask, half, ua, ub, sa, sb, r, d;
    logic ov, bo;
    mask = (1 << n) - 1;
    half = 1 << (n - 1);
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    d  = (ua - ub) & mask;
    sa = (ua >= half) ? ua - (1 << n) : ua;
    sb = (ub >= half) ? ub - (1 << n) : ub;
    r  = sa - sb;
    ov = (r < -half) || (r > half - 1);
    bo = ua < ub;
    return {ov, bo, 8'(d)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver + scoreboard for one complete transaction
  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b,
                       input int hold, input bit poke,
                       output logic [7:0] d, output logic bo, output logic of);
    int n;
    int k;
    int guard;
    bit run_ok;
    logic [9:0] got;
    logic [9:0] e;
    n = nw(w);
    guard = 0;
    while (!irv[w] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", 32'(irv[w]), 1);
    av[w] = a;
    bv[w] = b;
    iv[w] = 1'b1;
    exp_q.push_back(model(n, a, b));
    @(negedge clk);
    iv[w] = 1'b0;
    k = 1;
    run_ok = 1'b1;
    while (!ovv[w] && k <= 20) begin
      if (irv[w]) run_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(n + 1));
    chk("in_ready_run", 32'(run_ok), 1);
    got = {ofv[w], bov[w], dv[w]};
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(ovv[w]), 1);
      chk("hold_in_ready", 32'(irv[w]), 0);
      chk("hold_stable", 32'({ofv[w], bov[w], dv[w]}), 32'(got));
      iv[w] = poke;
      if (poke) begin
        av[w] = 8'($urandom);
        bv[w] = 8'($urandom);
      end
      @(negedge clk);
    end
    iv[w] = 1'b0;
    orv[w] = 1'b1;
    @(negedge clk);
    orv[w] = 1'b0;
    chk("post_valid", 32'(ovv[w]), 0);
    chk("post_in_ready", 32'(irv[w]), 1);
    chk("post_hold", 32'({ofv[w], bov[w], dv[w]}), 32'(got));
    e = exp_q.pop_front();
    chk("model", 32'(got), 32'(e));
    d  = got[7:0];
    bo = got[8];
    of = got[9];
  endtask

  initial begin
    logic [7:0] d;
    logic bo, of;
    int w;

    vecs[0]  = '{0, 8'd5,    8'd3,    0,  1'b0, 8'd2,    1'b0, 1'b0};
    vecs[1]  = '{0, 8'd3,    8'd5,    0,  1'b0, 8'd14,   1'b1, 1'b0};
    vecs[2]  = '{0, 8'd8,    8'd1,    0,  1'b0, 8'd7,    1'b0, 1'b1};
    vecs[3]  = '{0, 8'd0,    8'd0,    0,  1'b0, 8'd0,    1'b0, 1'b0};
    vecs[4]  = '{0, 8'd15,   8'd15,   0,  1'b0, 8'd0,    1'b0, 1'b0};
    vecs[5]  = '{0, 8'd0,    8'd15,   0,  1'b0, 8'd1,    1'b1, 1'b0};
    vecs[6]  = '{0, 8'd5,    8'd3,    10, 1'b1, 8'd2,    1'b0, 1'b0};
    vecs[7]  = '{1, 8'd0,    8'd1,    0,  1'b0, 8'd1,    1'b1, 1'b1};
    vecs[8]  = '{1, 8'd1,    8'd1,    0,  1'b0, 8'd0,    1'b0, 1'b0};
    vecs[9]  = '{1, 8'd1,    8'd0,    2,  1'b1, 8'd1,    1'b0, 1'b0};
    vecs[10] = '{2, 8'h80,   8'h01,   0,  1'b0, 8'h7f,   1'b0, 1'b1};
    vecs[11] = '{2, 8'h7f,   8'hff,   3,  1'b0, 8'h80,   1'b1, 1'b1};

    n_checks = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; orv[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 32'(irv[i]), 1);
      chk("rst_out_valid", 32'(ovv[i]), 0);
      chk("rst_diff", 32'(dv[i]), 0);
      chk("rst_borrow", 32'(bov[i]), 0);
      chk("rst_overflow", 32'(ofv[i]), 0);
    end

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].poke, d, bo, of);
      chk("vec_diff", 32'(d), 32'(vecs[i].d));
      chk("vec_borrow", 32'(bo), 32'(vecs[i].bo));
      chk("vec_overflow", 32'(of), 32'(vecs[i].of));
    end

    // reset in the second RUN cycle, with a nonzero previous result held
    do_op(0, 8'd3, 8'd5, 0, 1'b0, d, bo, of);
    av[0] = 8'd9;
    bv[0] = 8'd4;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_diff", 32'(dv[0]), 0);
    chk("abort_borrow", 32'(bov[0]), 0);
    chk("abort_overflow", 32'(ofv[0]), 0);
    chk("abort_out_valid", 32'(ovv[0]), 0);
    chk("abort_in_ready", 32'(irv[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_result", 32'(ovv[0]), 0);
    end
    do_op(0, 8'd6, 8'd2, 0, 1'b0, d, bo, of);
    chk("after_rst_diff", 32'(d), 4);
    chk("after_rst_borrow", 32'(bo), 0);

    // random operands against the reference model
    for (int i = 0; i < 360; i++) begin
      if (i < 300) w = 2;
      else if (i < 345) w = 0;
      else w = 1;
      do_op(w, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), d, bo, of);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
